// File: rtl/mips_trace_pkg.sv
// Shared types and helpers for the MIPS writeback trace buffer.
// Holds the capture FSM encoding and the default trace entry layout.
package mips_trace_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_RA_W   = 4;
  localparam int DEF_PC_W   = 16;

  typedef struct packed {
    logic [DEF_PC_W-1:0]   pc;
    logic [DEF_RA_W-1:0]   addr;
    logic [DEF_DATA_W-1:0] data;
  } entry_t;

  function automatic int trace_idx_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace memory: one write port, one registered read port.
// Contents are intentionally not reset.
module trace_ram #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) q <= mem[raddr];
  end

endmodule

// File: rtl/mips_wb_trace_buffer.sv
// Writeback trace buffer: circular capture of WB events around a trigger.
// Probe-only; never back-pressures the pipeline.
module mips_wb_trace_buffer
  import mips_trace_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int RA_W      = 4,
  parameter int PC_W      = 16,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cap_en,
  input  logic [PC_W-1:0]             pc_in,
  input  logic                        wb_valid,
  input  logic [RA_W-1:0]             wb_addr,
  input  logic [DATA_W-1:0]           wb_data,
  input  logic                        trig_arm,
  input  logic                        trig_force,
  input  logic                        trig_pc_en,
  input  logic [PC_W-1:0]             trig_pc,
  input  logic                        rd_req,
  input  logic [trace_idx_w(DEPTH)-1:0] rd_idx,
  output logic [1:0]                  state,
  output logic                        done,
  output logic [trace_idx_w(DEPTH):0] count,
  output logic                        overflow,
  output logic                        rd_valid,
  output logic                        rd_err,
  output logic [PC_W-1:0]             rd_pc,
  output logic [RA_W-1:0]             rd_addr,
  output logic [DATA_W-1:0]           rd_data
);

  localparam int IDX_W = trace_idx_w(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam int ENT_W = PC_W + RA_W + DATA_W;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [IDX_W-1:0] POST_INIT = IDX_W'(POST_TRIG);

  state_t             st;
  logic [IDX_W-1:0]   wr_ptr;
  logic [IDX_W-1:0]   post_cnt;
  logic               trigger;
  logic               capturing;
  logic               wr_en;
  logic               rd_ok;
  logic [IDX_W-1:0]   oldest;
  logic [IDX_W-1:0]   rd_ptr;
  logic [ENT_W-1:0]   q;

  assign trigger   = trig_force || (trig_pc_en && (pc_in == trig_pc));
  assign capturing = (st == S_ARMED) || (st == S_POST);
  // Arm wins over a same-cycle write: the buffer is being cleared.
  assign wr_en     = cap_en && wb_valid && capturing && !trig_arm;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st       <= S_IDLE;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      post_cnt <= '0;
    end else if (trig_arm) begin
      st       <= S_ARMED;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      post_cnt <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + IDX_W'(1);
        if (count == FULL) overflow <= 1'b1;
        else count <= count + CNT_W'(1);
      end
      unique case (st)
        S_IDLE: ;
        S_ARMED: begin
          if (trigger) begin
            st       <= (POST_TRIG == 0) ? S_DONE : S_POST;
            post_cnt <= POST_INIT;
          end
        end
        S_POST: begin
          if (wr_en) begin
            post_cnt <= post_cnt - IDX_W'(1);
            if (post_cnt == IDX_W'(1)) st <= S_DONE;
          end
        end
        S_DONE: ;
      endcase
    end
  end

  // Once wrapped, the next slot to write holds the oldest entry.
  assign oldest = (overflow || (count == FULL)) ? wr_ptr : '0;
  assign rd_ptr = oldest + rd_idx;
  assign rd_ok  = (st == S_DONE) && ({1'b0, rd_idx} < count);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      rd_err   <= rd_req && !rd_ok;
    end
  end

  trace_ram #(
    .WIDTH(ENT_W),
    .DEPTH(DEPTH),
    .AW   (IDX_W)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en),
    .waddr(wr_ptr),
    .wdata({pc_in, wb_addr, wb_data}),
    .re   (rd_req && rd_ok),
    .raddr(rd_ptr),
    .q    (q)
  );

  assign {rd_pc, rd_addr, rd_data} =
    (rd_valid && !rd_err) ? q : '0;

  assign state = st;
  assign done  = (st == S_DONE);

endmodule
